// File: rtl/pe_issue_if.sv
// Issue-stage bus: imem load, run control, data-memory read ports, ALU operands and write-back.
// The master modport is the surrounding PE or bench, and the slave modport is the issue stage.
interface pe_issue_if #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 8,
  parameter int IAWIDTH = 10
);
  logic                  Inst_Wr_En;
  logic [IAWIDTH-1:0]    Inst_Wr_Addr;
  logic [4+4*AWIDTH-1:0] Inst_Wr_Data;
  logic                  Start;
  logic [IAWIDTH-1:0]    Inst_Num;
  logic [15:0]           Iter_Num;
  logic                  Busy;
  logic                  Done;
  logic [AWIDTH-1:0]     Dmem_Rd_Addr0, Dmem_Rd_Addr1, Dmem_Rd_Addr2;
  logic [DWIDTH-1:0]     Dmem_Rd_Data0, Dmem_Rd_Data1, Dmem_Rd_Data2;
  logic [DWIDTH-1:0]     ALU_In0, ALU_In1, ALU_In2;
  logic [3:0]            Opcode;
  logic                  Wb_En;
  logic [AWIDTH-1:0]     Wb_Addr;
  logic                  Wb_Conflict;

  modport master (
    output Inst_Wr_En, Inst_Wr_Addr, Inst_Wr_Data, Start, Inst_Num, Iter_Num,
           Dmem_Rd_Data0, Dmem_Rd_Data1, Dmem_Rd_Data2,
    input  Busy, Done, Dmem_Rd_Addr0, Dmem_Rd_Addr1, Dmem_Rd_Addr2,
           ALU_In0, ALU_In1, ALU_In2, Opcode, Wb_En, Wb_Addr, Wb_Conflict
  );

  modport slave (
    input  Inst_Wr_En, Inst_Wr_Addr, Inst_Wr_Data, Start, Inst_Num, Iter_Num,
           Dmem_Rd_Data0, Dmem_Rd_Data1, Dmem_Rd_Data2,
    output Busy, Done, Dmem_Rd_Addr0, Dmem_Rd_Addr1, Dmem_Rd_Addr2,
           ALU_In0, ALU_In1, ALU_In2, Opcode, Wb_En, Wb_Addr, Wb_Conflict
  );
endinterface

// File: rtl/pe_issue_stage.sv
// SCGRA PE issue stage: steps the local imem and fetches 3 operands per instruction. Issue to ALU_In/Opcode takes 3 cycles.
// Wb_En follows the ALU operands after LAT_LONG or LAT_SHORT cycles. There is no backpressure: one issue per RUN cycle.
module pe_issue_stage #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 8,
  parameter int IAWIDTH   = 10,
  parameter int LAT_LONG  = 4,
  parameter int LAT_SHORT = 3
) (
  input logic       Clk,
  input logic       Resetn,
  pe_issue_if.slave bus
);
  localparam int IWIDTH    = 4 + 4*AWIDTH;
  localparam int DRAIN_CYC = 3 + LAT_LONG;
  localparam int DCW       = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [IAWIDTH-1:0] pc, pc_nxt, inst_num_q;
  logic [15:0]        iter_cnt, iter_cnt_nxt, iter_last_q;
  logic [DCW-1:0]     drain_cnt, drain_cnt_nxt;
  logic               issue, done_nxt, done_q;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    iter_cnt_nxt  = iter_cnt;
    drain_cnt_nxt = drain_cnt;
    issue         = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt    = RUN;
          pc_nxt       = '0;
          iter_cnt_nxt = '0;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (pc == inst_num_q) begin
          pc_nxt = '0;
          if (iter_cnt == iter_last_q) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = '0;
          end else begin
            iter_cnt_nxt = iter_cnt + 16'd1;
          end
        end else begin
          pc_nxt = pc + IAWIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DCW'(DRAIN_CYC - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt + DCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      iter_cnt    <= '0;
      drain_cnt   <= '0;
      done_q      <= 1'b0;
      inst_num_q  <= '0;
      iter_last_q <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      iter_cnt  <= iter_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      done_q    <= done_nxt;
      if (state == IDLE && bus.Start) begin
        inst_num_q  <= bus.Inst_Num;
        iter_last_q <= (bus.Iter_Num == 16'd0) ? 16'd0 : bus.Iter_Num - 16'd1;
      end
    end
  end

  // Instruction RAM: synchronous read, no reset, and writable only while idle
  logic [IWIDTH-1:0] imem [0:(1<<IAWIDTH)-1];
  logic [IWIDTH-1:0] inst_q;

  always_ff @(posedge Clk) begin
    if (bus.Inst_Wr_En && state == IDLE) imem[bus.Inst_Wr_Addr] <= bus.Inst_Wr_Data;
    inst_q <= imem[pc];
  end

  logic              v1, v2;
  logic [3:0]        op2, opcode_q;
  logic [AWIDTH-1:0] dst2, dst3;
  logic [DWIDTH-1:0] alu0_q, alu1_q, alu2_q;

  assign bus.Dmem_Rd_Addr0 = v1 ? inst_q[3*AWIDTH-1 -: AWIDTH] : '0;
  assign bus.Dmem_Rd_Addr1 = v1 ? inst_q[2*AWIDTH-1 -: AWIDTH] : '0;
  assign bus.Dmem_Rd_Addr2 = v1 ? inst_q[AWIDTH-1:0]           : '0;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      op2      <= '0;
      dst2     <= '0;
      dst3     <= '0;
      opcode_q <= '0;
      alu0_q   <= '0;
      alu1_q   <= '0;
      alu2_q   <= '0;
    end else begin
      v1       <= issue;
      v2       <= v1;
      op2      <= inst_q[IWIDTH-1 -: 4];
      dst2     <= inst_q[4*AWIDTH-1 -: AWIDTH];
      dst3     <= dst2;
      opcode_q <= v2 ? op2 : 4'd0;
      alu0_q   <= v2 ? bus.Dmem_Rd_Data0 : '0;
      alu1_q   <= v2 ? bus.Dmem_Rd_Data1 : '0;
      alu2_q   <= v2 ? bus.Dmem_Rd_Data2 : '0;
    end
  end

  assign bus.Opcode  = opcode_q;
  assign bus.ALU_In0 = alu0_q;
  assign bus.ALU_In1 = alu1_q;
  assign bus.ALU_In2 = alu2_q;

  // Slot 0 drives Wb_En. An entry written into slot L-1 appears L cycles after its opcode
  logic [LAT_LONG-1:0] wb_v;
  logic [AWIDTH-1:0]   wb_dst [LAT_LONG];
  logic                is_long, is_short, short_slot_busy, wb_conflict_q;

  always_comb begin
    is_long  = opcode_q inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    is_short = opcode_q inside {4'd6, 4'd9, 4'd10, 4'd11};
  end

  if (LAT_SHORT < LAT_LONG) begin : g_short_chk
    assign short_slot_busy = wb_v[LAT_SHORT];
  end else begin : g_short_nochk
    assign short_slot_busy = 1'b0;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wb_v          <= '0;
      wb_conflict_q <= 1'b0;
      for (int i = 0; i < LAT_LONG; i++) wb_dst[i] <= '0;
    end else begin
      for (int i = 0; i < LAT_LONG-1; i++) begin
        wb_v[i]   <= wb_v[i+1];
        wb_dst[i] <= wb_dst[i+1];
      end
      wb_v[LAT_LONG-1] <= 1'b0;
      if (is_long) begin
        wb_v[LAT_LONG-1]   <= 1'b1;
        wb_dst[LAT_LONG-1] <= dst3;
      end else if (is_short) begin
        // The older long-class entry keeps the slot and the short one is dropped
        if (short_slot_busy) begin
          wb_conflict_q <= 1'b1;
        end else begin
          wb_v[LAT_SHORT-1]   <= 1'b1;
          wb_dst[LAT_SHORT-1] <= dst3;
        end
      end
    end
  end

  assign bus.Wb_En       = wb_v[0];
  assign bus.Wb_Addr     = wb_v[0] ? wb_dst[0] : '0;
  assign bus.Wb_Conflict = wb_conflict_q;
  assign bus.Busy        = (state != IDLE);
  assign bus.Done        = done_q;
endmodule

// File: tb/tb_pe_issue_stage.sv
// Bench for pe_issue_stage: directed and random programs are checked cycle by cycle.
// A reference model computes the expected timeline from the issue and write-back rules.
module tb_pe_issue_stage;
  localparam int DW = 32, AW = 8, IAW = 10, LL = 4, LS = 3;

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clk = ~Clk;

  pe_issue_if #(.DWIDTH(DW), .AWIDTH(AW), .IAWIDTH(IAW)) bus ();

  pe_issue_stage #(.DWIDTH(DW), .AWIDTH(AW), .IAWIDTH(IAW), .LAT_LONG(LL), .LAT_SHORT(LS)) dut (
    .Clk(Clk), .Resetn(Resetn), .bus(bus)
  );

  // Data memory with a 1-cycle synchronous read on three ports
  logic [DW-1:0] dm [256];
  always @(posedge Clk) begin
    bus.Dmem_Rd_Data0 <= dm[bus.Dmem_Rd_Addr0];
    bus.Dmem_Rd_Data1 <= dm[bus.Dmem_Rd_Addr1];
    bus.Dmem_Rd_Data2 <= dm[bus.Dmem_Rd_Addr2];
  end

  int errors = 0;
  int checks = 0;
  bit exp_conf = 1'b0;

  logic [3:0]    p_op  [16];
  logic [AW-1:0] p_dst [16], p_s0 [16], p_s1 [16], p_s2 [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return LL;
      4'd6, 4'd9, 4'd10, 4'd11:     return LS;
      default:                      return 0;
    endcase
  endfunction

  task automatic set_instr(input int i, input int op, input int dst, input int s0, input int s1, input int s2);
    p_op[i] = 4'(op); p_dst[i] = AW'(dst); p_s0[i] = AW'(s0); p_s1[i] = AW'(s1); p_s2[i] = AW'(s2);
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i <= n; i++) begin
      bus.Inst_Wr_En   = 1'b1;
      bus.Inst_Wr_Addr = IAW'(i);
      bus.Inst_Wr_Data = {p_op[i], p_dst[i], p_s0[i], p_s1[i], p_s2[i]};
      step();
    end
    bus.Inst_Wr_En = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},   64'(bus.Busy), 64'(0));
    chk({tag, ".done"},   64'(bus.Done), 64'(0));
    chk({tag, ".opcode"}, 64'(bus.Opcode), 64'(0));
    chk({tag, ".alu0"},   64'(bus.ALU_In0), 64'(0));
    chk({tag, ".alu1"},   64'(bus.ALU_In1), 64'(0));
    chk({tag, ".alu2"},   64'(bus.ALU_In2), 64'(0));
    chk({tag, ".wben"},   64'(bus.Wb_En), 64'(0));
    chk({tag, ".wbaddr"}, 64'(bus.Wb_Addr), 64'(0));
    chk({tag, ".rdaddr0"}, 64'(bus.Dmem_Rd_Addr0), 64'(0));
    chk({tag, ".rdaddr1"}, 64'(bus.Dmem_Rd_Addr1), 64'(0));
    chk({tag, ".rdaddr2"}, 64'(bus.Dmem_Rd_Addr2), 64'(0));
    chk({tag, ".conflict"}, 64'(bus.Wb_Conflict), 64'(0));
  endtask

  // Call in cycle 0 (1 time unit after an edge). Start is driven now and the run is checked up to tend.
  task automatic run_prog(input int inum, input int iters, input bit chain,
                          input int ign_start_t, input int ign_wr_t, input int abort_t);
    int n, tdone, tend;
    logic [3:0]    e_op [128];
    logic [DW-1:0] e_in0 [128], e_in1 [128], e_in2 [128];
    logic [AW-1:0] e_a0 [128], e_a1 [128], e_a2 [128], e_wa [128];
    bit            e_av [128], e_wb [128];
    n     = (inum + 1) * ((iters == 0) ? 1 : iters);
    tdone = n + 4 + LL;
    tend  = chain ? tdone : tdone + 3;
    for (int t = 0; t < 128; t++) begin
      e_op[t] = '0; e_in0[t] = '0; e_in1[t] = '0; e_in2[t] = '0;
      e_a0[t] = '0; e_a1[t] = '0; e_a2[t] = '0; e_wa[t] = '0;
      e_av[t] = 1'b0; e_wb[t] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      int p, l;
      p = k % (inum + 1);
      e_av[2+k] = 1'b1;
      e_a0[2+k] = p_s0[p]; e_a1[2+k] = p_s1[p]; e_a2[2+k] = p_s2[p];
      e_op[4+k] = p_op[p];
      e_in0[4+k] = dm[p_s0[p]]; e_in1[4+k] = dm[p_s1[p]]; e_in2[4+k] = dm[p_s2[p]];
      l = lat_of(p_op[p]);
      if (l > 0) begin
        if (e_wb[4+k+l]) exp_conf = 1'b1;
        else begin
          e_wb[4+k+l] = 1'b1;
          e_wa[4+k+l] = p_dst[p];
        end
      end
    end

    bus.Inst_Num = IAW'(inum);
    bus.Iter_Num = 16'(iters);
    bus.Start    = 1'b1;
    for (int t = 1; t <= tend; t++) begin
      step();
      if (t == 1) begin
        bus.Start    = 1'b0;
        bus.Inst_Num = IAW'(7);
        bus.Iter_Num = 16'd5;
      end
      if (t == ign_start_t) bus.Start = 1'b1;
      if (t == ign_start_t + 1) bus.Start = 1'b0;
      if (t == ign_wr_t) begin
        bus.Inst_Wr_En   = 1'b1;
        bus.Inst_Wr_Addr = '0;
        bus.Inst_Wr_Data = {4'hB, AW'(8'hEE), AW'(8'hED), AW'(8'hEC), AW'(8'hEB)};
      end
      if (t == ign_wr_t + 1) bus.Inst_Wr_En = 1'b0;
      if (t == abort_t) begin
        #2 Resetn = 1'b0;
        #1;
        exp_conf = 1'b0;
        chk_all_zero($sformatf("abort@%0d", t));
        return;
      end
      chk($sformatf("busy@%0d", t), 64'(bus.Busy), 64'(t <= n + 3 + LL));
      chk($sformatf("done@%0d", t), 64'(bus.Done), 64'(t == tdone));
      chk($sformatf("opcode@%0d", t), 64'(bus.Opcode), 64'(e_op[t]));
      chk($sformatf("alu0@%0d", t), 64'(bus.ALU_In0), 64'(e_in0[t]));
      chk($sformatf("alu1@%0d", t), 64'(bus.ALU_In1), 64'(e_in1[t]));
      chk($sformatf("alu2@%0d", t), 64'(bus.ALU_In2), 64'(e_in2[t]));
      if (e_av[t]) begin
        chk($sformatf("rdaddr0@%0d", t), 64'(bus.Dmem_Rd_Addr0), 64'(e_a0[t]));
        chk($sformatf("rdaddr1@%0d", t), 64'(bus.Dmem_Rd_Addr1), 64'(e_a1[t]));
        chk($sformatf("rdaddr2@%0d", t), 64'(bus.Dmem_Rd_Addr2), 64'(e_a2[t]));
      end
      chk($sformatf("wben@%0d", t), 64'(bus.Wb_En), 64'(e_wb[t]));
      if (e_wb[t]) chk($sformatf("wbaddr@%0d", t), 64'(bus.Wb_Addr), 64'(e_wa[t]));
    end
    chk("conflict_end", 64'(bus.Wb_Conflict), 64'(exp_conf));
  endtask

  initial begin
    bus.Inst_Wr_En = 1'b0; bus.Inst_Wr_Addr = '0; bus.Inst_Wr_Data = '0;
    bus.Start = 1'b0; bus.Inst_Num = '0; bus.Iter_Num = '0;
    for (int a = 0; a < 256; a++) dm[a] = DW'(a + 100);

    step(); step();
    chk_all_zero("reset");
    Resetn = 1'b1;
    step();

    // Long/short collision, then a short op landing one cycle later
    set_instr(0, 1, 10, 1, 2, 3);
    set_instr(1, 6, 11, 4, 5, 6);
    set_instr(2, 10, 12, 7, 8, 9);
    load_prog(2);
    run_prog(2, 1, 1'b0, -1, -1, -1);

    // Single instruction with Iter_Num=0
    set_instr(0, 3, 20, 21, 22, 23);
    load_prog(0);
    run_prog(0, 0, 1'b0, -1, -1, -1);

    // Wrap without bubbles, undefined opcode, ignored Start and write while busy, and a Start in the Done cycle
    set_instr(0, 2, 30, 31, 32, 33);
    set_instr(1, 7, 34, 35, 36, 37);
    load_prog(1);
    run_prog(1, 3, 1'b1, 2, 3, -1);
    run_prog(1, 1, 1'b0, -1, -1, -1);

    // Reset in cycle 3 of a run, then a clean restart
    run_prog(1, 3, 1'b0, -1, -1, 3);
    step(); step();
    Resetn = 1'b1;
    for (int t = 0; t < 12; t++) begin
      step();
      chk($sformatf("postrst_done@%0d", t), 64'(bus.Done), 64'(0));
      chk($sformatf("postrst_busy@%0d", t), 64'(bus.Busy), 64'(0));
    end
    load_prog(1);
    run_prog(1, 2, 1'b0, -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      int inum, iters;
      inum  = $urandom_range(0, 7);
      iters = $urandom_range(0, 3);
      for (int a = 0; a < 256; a++) dm[a] = $urandom;
      for (int i = 0; i <= inum; i++)
        set_instr(i, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
      load_prog(inum);
      run_prog(inum, iters, r[0], -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_issue_stage.md
# pe_issue_stage

Instruction issue and operand fetch stage of an SCGRA processing element. It sits directly upstream of the PE's 3-input, 4-bit-opcode pipelined ALU. It holds a locally loaded instruction memory and steps through it for a programmed number of iterations. For each instruction it reads three operands from the PE data memory and presents them to the ALU with the opcode aligned. It also emits the matching write-back enable and destination address aligned to the cycle the ALU result appears.

## Interface
Parameters:
- DWIDTH, 32, operand width
- AWIDTH, 8, data-memory address width
- IAWIDTH, 10, instruction-memory address width (1K instructions)
- LAT_LONG, 4, ALU input-to-output latency for opcodes 0001–0101
- LAT_SHORT, 3, ALU input-to-output latency for opcodes 0110, 1001, 1010, 1011

Ports:
- Clk  in  1  clock; all state on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Inst_Wr_En  in  1  instruction-memory write strobe
- Inst_Wr_Addr  in  IAWIDTH  instruction write address
- Inst_Wr_Data  in  4+4*AWIDTH  instruction word: [top 4] opcode, then dst, src0, src1, src2 (src2 in LSBs)
- Start  in  1  one-cycle start request
- Inst_Num  in  IAWIDTH  index of last instruction per iteration
- Iter_Num  in  16  iteration count; 0 is treated as 1
- Busy  out  1  high from RUN entry until Done
- Done  out  1  one-cycle completion pulse
- Dmem_Rd_Addr0/1/2  out  AWIDTH  data-memory read addresses (memory has 1-cycle synchronous read)
- Dmem_Rd_Data0/1/2  in  DWIDTH  data-memory read data
- ALU_In0/1/2  out  DWIDTH  registered ALU operands
- Opcode  out  4  registered ALU opcode; 0000 = bubble
- Wb_En  out  1  write-back strobe, aligned with ALU output
- Wb_Addr  out  AWIDTH  write-back destination
- Wb_Conflict  out  1  sticky schedule-error flag

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - Start=1 latches Inst_Num and Iter_Num, clears PC and the iteration counter, and enters RUN.
  - Inst_Wr_En writes instruction memory only in IDLE; it is ignored otherwise.
- RUN:
  - One instruction issues per cycle, PC=0..Inst_Num.
  - At PC==Inst_Num: if the iteration counter equals Iter_Num-1, go to DRAIN; otherwise PC←0 and the counter increments. There is no bubble at wrap.
- DRAIN:
  - Issues nothing and counts 3+LAT_LONG cycles, then returns to IDLE and pulses Done.
- Start is ignored while Busy.
- Fetch pipe: instruction-memory read → decode/drive Dmem_Rd_Addr → data return → register ALU_In*/Opcode. Each stage carries a valid bit; invalid slots drive Opcode=0000 and ALU_In*=0.
- Write-back delay line:
  - Depth LAT_LONG; each entry holds {valid, dst}.
  - An opcode of class 0001–0101 inserts at depth LAT_LONG. Class 0110/1001/1010/1011 inserts at depth LAT_SHORT.
  - Opcode 0000 and undefined opcodes (0111, 1000, 11xx) insert nothing and produce no write-back.
- Conflict: if a short-class insert targets a slot already holding a valid long-class entry, keep the older long entry and drop the new one. Set Wb_Conflict; it clears only on reset.
- Reset, including mid-run:
  - Opcode, ALU_In*, Wb_En, Wb_Addr, Dmem_Rd_Addr*, Busy, Done and Wb_Conflict all go to 0.
  - FSM goes to IDLE; the delay line and pipe valids are flushed.
  - No Done pulse follows a reset.
  - Instruction-memory contents are not guaranteed after reset.

## Timing
- Start sampled high at edge of cycle 0. RUN covers cycles 1..N, where N = (Inst_Num+1)·max(Iter_Num,1).
- For issued instruction k (0-based), counting from cycle 1:
  - Instruction read in cycle 1+k.
  - Dmem_Rd_Addr* valid in cycle 2+k.
  - Dmem_Rd_Data* sampled in cycle 3+k.
  - ALU_In*/Opcode valid in cycle 4+k.
  - Wb_En=1 with Wb_Addr=dst in cycle 4+k+L, where L is the class latency.
- Busy is high in cycles 1..N+3+LAT_LONG. Done is high in cycle N+4+LAT_LONG, the same cycle Busy reads 0.
- A Start in the Done cycle is accepted; the new RUN begins the next cycle.

## Test plan
- Load 3 instructions (0001 dst=10 src=1,2,3; 0110 dst=11; 1010 dst=12). Set Inst_Num=2, Iter_Num=1, with memory returning addr+100 as data. Start at cycle 0 → Opcode 1,6,10 in cycles 4,5,6 with ALU_In0/1/2 = 101,102,103 for the first. Wb_En at cycles 8 (addr 10), 8 (addr 11) → conflict: Wb_Conflict=1 and only addr 10 written. The third gives Wb addr 12 at cycle 9. Done at cycle 11.
- Inst_Num=0, Iter_Num=0 (treated as 1) → single issue; Done at cycle 9.
- Inst_Num=1, Iter_Num=3 → PC sequence 0,1,0,1,0,1 with no bubbles; Done at cycle 14.
- Opcode 0111 in program → ALU sees 0111 but no Wb_En in any cycle for it.
- Reset asserted in cycle 3 of a run → all outputs 0 asynchronously, no Done. A Start after release restarts from PC 0.
- Start pulsed at cycle 2 of an active run, and Inst_Wr_En while Busy → ignored; the program and completion timing are unchanged.
